// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_register.sv
// Program counter with hold / +4 / redirect next-pc selection and target alignment check.
module pc_register
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        advance,
    input  logic        load,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        target_aligned
);

    assign pc_plus4       = pc + 32'(WORD_BYTES);
    assign target_aligned = (target[1:0] == 2'b00);

    // A load (redirect) outranks advance; neither asserted means hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pc <= RESET_PC;
        else if (load)
            pc <= target;
        else if (advance)
            pc <= pc_plus4;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: addresses instruction memory from pc and registers the word into a valid/ready slot for decode.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fault
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         target_aligned;
    logic         slot_free;
    logic         in_range;
    logic         load;
    logic         advance;

    assign imem_address = {2'b00, pc[31:2]};
    assign slot_free    = !out_valid || out_ready;
    assign in_range     = imem_address < 32'(MEM_WORDS);
    assign load         = redirect_valid && target_aligned && (state != FAULT);
    assign advance      = (state == RUN) && !redirect_valid && slot_free && in_range;

    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clk            (clk),
        .reset_n        (reset_n),
        .advance        (advance),
        .load           (load),
        .target         (redirect_target),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .target_aligned (target_aligned)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= BOOT;
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_pc          <= '0;
            out_pc_plus4    <= '0;
            fault           <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (redirect_valid && !target_aligned) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Redirect flushes the slot even when decode is stalled.
                    if (redirect_valid) begin
                        out_valid <= 1'b0;
                        if (!target_aligned) begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end
                    end else if (slot_free) begin
                        if (in_range) begin
                            out_valid       <= 1'b1;
                            out_instruction <= imem_instruction;
                            out_pc          <= pc;
                            out_pc_plus4    <= pc_plus4;
                        end else begin
                            out_valid <= 1'b0;
                            fault     <= 1'b1;
                            state     <= FAULT;
                        end
                    end
                end
                FAULT: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: state <= FAULT;
            endcase
        end
    end

endmodule
